mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default `DATA_WIDTH (32), memory data width in bits.
REQ-002 Parameter AW, default `ADDRESS_WIDTH (32), memory address width in bits.
REQ-003 Parameter MAX_WAIT, default 15, cycles in BUSY before timeout; legal range 1-255.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 i_r0_addr_valid  in  1  requester 0 (instruction fetch) request; held high until its o_r0_valid pulse.
REQ-007 i_r0_addr  in  AW  requester 0 cell address; read-only port.
REQ-008 i_r1_addr_valid  in  1  requester 1 (load/store) request; same hold rule.
REQ-009 i_r1_addr  in  AW  requester 1 cell address.
REQ-010 i_r1_we  in  1  requester 1 write enable: 1 = write, 0 = read.
REQ-011 i_r1_wdata  in  DW  requester 1 write data.
REQ-012 o_r0_valid / o_r1_valid  out  1 each  one-cycle response strobe to the granted requester.
REQ-013 o_rsp_data  out  DW  read data, shared by both requesters; qualified by the strobes.
REQ-014 o_rsp_err  out  1  timeout flag, qualified by the strobes.
REQ-015 o_mem_addr_valid  out  1  request to memory.
REQ-016 o_mem_addr  out  AW  latched address.
REQ-017 o_mem_we  out  1  latched write enable.
REQ-018 o_mem_wdata  out  DW  latched write data.
REQ-019 i_mem_valid  in  1  memory completion.
REQ-020 i_mem_data  in  DW  memory read data.
REQ-021 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-022 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, held in a 2-bit state register.
REQ-023 IDLE, both addr_valids low -> remain in IDLE.
REQ-024 IDLE, one or both addr_valids high -> grant one requester, latch its address, we and wdata into the o_mem_* registers, go to BUSY.
  - Requester 0 latches we = 0 and wdata = 0.
REQ-025 Round-robin grant pointer last_grant:
  - Simultaneous requests go to the requester that is not last_grant.
  - A single request is granted regardless of last_grant.
  - last_grant updates to the winner at grant time.
REQ-026 o_mem_addr_valid SHALL be 1 exactly while state = BUSY; first high cycle is the cycle after the grant edge.
REQ-027 BUSY with i_mem_valid = 1:
  - register i_mem_data into o_rsp_data; clear o_rsp_err;
  - go to RESP; wait counter clears.
REQ-028 BUSY without i_mem_valid:
  - increment the 8-bit wait counter;
  - the cycle the counter equals MAX_WAIT-1, go to RESP with o_rsp_data = 0 and o_rsp_err = 1.
REQ-029 RESP lasts exactly one cycle, drives only the granted requester's o_rN_valid high, then returns to IDLE.
REQ-030 Minimum transaction latency: request visible at edge N -> o_rN_valid high in cycle N+2 when memory answers in the first BUSY cycle.
  - Minimum one IDLE cycle between consecutive grants.
REQ-031 For writes (o_mem_we = 1), o_rsp_data SHALL carry i_mem_data as presented; requesters ignore it.
REQ-032 i_mem_valid in IDLE or RESP SHALL be ignored: no state or output change, e.g. a late response after a timeout.
REQ-033 A requester dropping addr_valid while granted SHALL NOT abort the transaction: it completes and its strobe still pulses.
REQ-034 Latched address, we and wdata SHALL be stable throughout BUSY, independent of requester input changes.
REQ-035 A requester's strobe SHALL never pulse without a preceding grant to that requester.

Reset
REQ-036 Reset asserted SHALL force, asynchronously:
  - state = IDLE; last_grant = 1 (requester 0 wins the first tie); wait counter = 0;
  - o_mem_addr_valid = 0, o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0;
  - o_r0_valid = o_r1_valid = 0, o_rsp_data = 0, o_rsp_err = 0, o_busy = 0.
REQ-037 Reset mid-BUSY SHALL drop o_mem_addr_valid immediately; the in-flight transaction is discarded with no strobe.
REQ-038 The first grant after reset deasserts SHALL occur no earlier than the first rising edge with reset high.

Verification
REQ-039 Tie after reset: r0 @0x100 and r1 read @0x200 raised together; memory answers 0xAAAA5555 after 2 cycles.
  - r0 granted first (o_mem_addr = 0x100); o_r0_valid carries 0xAAAA5555.
  - Then 0x200 is issued and o_r1_valid pulses.
REQ-040 Alternation: both requesters held continuously for 6 transactions -> grant order r0, r1, r0, r1, r0, r1.
  - One IDLE cycle between each grant.
REQ-041 Write: r1 we = 1 @0x40, wdata 0xDEADBEEF.
  - o_mem_we = 1 and o_mem_wdata = 0xDEADBEEF throughout BUSY; o_r1_valid pulses once with err = 0.
REQ-042 Timeout with MAX_WAIT = 4, memory silent:
  - o_mem_addr_valid high exactly 4 cycles;
  - o_r0_valid pulses with err = 1, data 0;
  - a late i_mem_valid in IDLE causes no strobe.
REQ-043 Reset pulse mid-BUSY: o_mem_addr_valid falls in the same cycle with no strobe; the next tie is granted to r0.
REQ-044 Single-cycle memory: i_mem_valid returned in the first BUSY cycle.
  - o_rN_valid exactly 2 cycles after the request edge; o_busy high for exactly 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant between an instruction
// fetch port (r0, read-only) and a load/store port (r1), one outstanding
// memory transaction at a time, with a per-transaction timeout.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif

module mem_arbiter #(
  parameter int DW       = `DATA_WIDTH,
  parameter int AW       = `ADDRESS_WIDTH,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_r0_addr_valid,
  input  logic [AW-1:0] i_r0_addr,
  input  logic          i_r1_addr_valid,
  input  logic [AW-1:0] i_r1_addr,
  input  logic          i_r1_we,
  input  logic [DW-1:0] i_r1_wdata,
  output logic          o_r0_valid,
  output logic          o_r1_valid,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_mem_addr_valid,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_valid,
  input  logic [DW-1:0] i_mem_data,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait counter value on the last BUSY cycle before giving up.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e        state_q;
  logic          last_grant_q;   // 1 = r1 was granted most recently / currently
  logic [7:0]    wait_cnt_q;
  logic          r0_valid_q;
  logic          r1_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;
  logic          mem_addr_valid_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  logic          busy_q;
  logic          grant_r1_d;

  // Winner selection: a tie goes to the requester that did not win last time.
  always_comb begin
    grant_r1_d = 1'b0;
    if (i_r0_addr_valid && i_r1_addr_valid) begin
      grant_r1_d = ~last_grant_q;
    end else if (i_r1_addr_valid) begin
      grant_r1_d = 1'b1;
    end else begin
      grant_r1_d = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      wait_cnt_q       <= 8'd0;
      r0_valid_q       <= 1'b0;
      r1_valid_q       <= 1'b0;
      rsp_data_q       <= '0;
      rsp_err_q        <= 1'b0;
      mem_addr_valid_q <= 1'b0;
      mem_addr_q       <= '0;
      mem_we_q         <= 1'b0;
      mem_wdata_q      <= '0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          r0_valid_q <= 1'b0;
          r1_valid_q <= 1'b0;
          if (i_r0_addr_valid || i_r1_addr_valid) begin
            state_q          <= BUSY;
            mem_addr_valid_q <= 1'b1;
            busy_q           <= 1'b1;
            last_grant_q     <= grant_r1_d;
            wait_cnt_q       <= 8'd0;
            if (grant_r1_d) begin
              mem_addr_q  <= i_r1_addr;
              mem_we_q    <= i_r1_we;
              mem_wdata_q <= i_r1_wdata;
            end else begin
              // Instruction fetch never writes.
              mem_addr_q  <= i_r0_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end else begin
            state_q          <= IDLE;
            mem_addr_valid_q <= 1'b0;
            busy_q           <= 1'b0;
          end
        end
        BUSY: begin
          if (i_mem_valid) begin
            state_q          <= RESP;
            mem_addr_valid_q <= 1'b0;
            rsp_data_q       <= i_mem_data;
            rsp_err_q        <= 1'b0;
            wait_cnt_q       <= 8'd0;
            r0_valid_q       <= ~last_grant_q;
            r1_valid_q       <= last_grant_q;
          end else if (wait_cnt_q == LAST_WAIT) begin
            // Memory never answered: complete with an error response.
            state_q          <= RESP;
            mem_addr_valid_q <= 1'b0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b1;
            wait_cnt_q       <= 8'd0;
            r0_valid_q       <= ~last_grant_q;
            r1_valid_q       <= last_grant_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          r0_valid_q <= 1'b0;
          r1_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q          <= IDLE;
          mem_addr_valid_q <= 1'b0;
          r0_valid_q       <= 1'b0;
          r1_valid_q       <= 1'b0;
          busy_q           <= 1'b0;
          wait_cnt_q       <= 8'd0;
        end
      endcase
    end
  end

  assign o_r0_valid       = r0_valid_q;
  assign o_r1_valid       = r1_valid_q;
  assign o_rsp_data       = rsp_data_q;
  assign o_rsp_err        = rsp_err_q;
  assign o_mem_addr_valid = mem_addr_valid_q;
  assign o_mem_addr       = mem_addr_q;
  assign o_mem_we         = mem_we_q;
  assign o_mem_wdata      = mem_wdata_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: tie-break, alternation, write, timeout,
// mid-transaction reset and single-cycle latency.
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        r0_av, r1_av, r1_we, mem_valid;
  logic [31:0] r0_addr, r1_addr, r1_wdata, mem_data;
  logic        r0_v, r1_v, rsp_err, mem_av, mem_we, busy;
  logic [31:0] rsp_data, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DW(32), .AW(32), .MAX_WAIT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_r0_addr_valid  (r0_av),
    .i_r0_addr        (r0_addr),
    .i_r1_addr_valid  (r1_av),
    .i_r1_addr        (r1_addr),
    .i_r1_we          (r1_we),
    .i_r1_wdata       (r1_wdata),
    .o_r0_valid       (r0_v),
    .o_r1_valid       (r1_v),
    .o_rsp_data       (rsp_data),
    .o_rsp_err        (rsp_err),
    .o_mem_addr_valid (mem_av),
    .o_mem_addr       (mem_addr),
    .o_mem_we         (mem_we),
    .o_mem_wdata      (mem_wdata),
    .i_mem_valid      (mem_valid),
    .i_mem_data       (mem_data),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; r0_av = 1'b0; r1_av = 1'b0; r1_we = 1'b0; mem_valid = 1'b0;
    r0_addr = 32'h0; r1_addr = 32'h0; r1_wdata = 32'h0; mem_data = 32'h0;
    tick(); tick();
    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_av", {31'd0, mem_av}, 32'd0);
    check("rst_r0_v", {31'd0, r0_v}, 32'd0);
    check("rst_r1_v", {31'd0, r1_v}, 32'd0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b1;

    // Tie after reset: r0 wins, memory answers after 2 cycles
    r0_av = 1'b1; r0_addr = 32'h100; r1_av = 1'b1; r1_addr = 32'h200;
    tick();
    check("tie_av", {31'd0, mem_av}, 32'd1);
    check("tie_addr", mem_addr, 32'h100);
    check("tie_we", {31'd0, mem_we}, 32'd0);
    check("tie_busy", {31'd0, busy}, 32'd1);
    tick();
    check("tie_wait_av", {31'd0, mem_av}, 32'd1);
    mem_valid = 1'b1; mem_data = 32'hAAAA5555;
    tick();
    check("tie_r0_v", {31'd0, r0_v}, 32'd1);
    check("tie_r1_v", {31'd0, r1_v}, 32'd0);
    check("tie_data", rsp_data, 32'hAAAA5555);
    check("tie_err", {31'd0, rsp_err}, 32'd0);
    check("tie_resp_av", {31'd0, mem_av}, 32'd0);
    mem_valid = 1'b0; r0_av = 1'b0;
    tick();
    check("tie_idle_busy", {31'd0, busy}, 32'd0);
    check("tie_idle_r0_v", {31'd0, r0_v}, 32'd0);
    tick();
    check("tie2_addr", mem_addr, 32'h200);
    check("tie2_av", {31'd0, mem_av}, 32'd1);
    mem_valid = 1'b1; mem_data = 32'h12345678;
    tick();
    check("tie2_r1_v", {31'd0, r1_v}, 32'd1);
    check("tie2_r0_v", {31'd0, r0_v}, 32'd0);
    check("tie2_data", rsp_data, 32'h12345678);
    mem_valid = 1'b0; r1_av = 1'b0;
    tick();
    check("tie2_idle", {31'd0, busy}, 32'd0);

    // Alternation: both held, memory valid held high (ignored in IDLE/RESP)
    r0_av = 1'b1; r1_av = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_data = 32'h1000 + 32'(i);
      tick();
      check("alt_addr", mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      check("alt_av", {31'd0, mem_av}, 32'd1);
      tick();
      check("alt_r0_v", {31'd0, r0_v}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_r1_v", {31'd0, r1_v}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check("alt_data", rsp_data, 32'h1000 + 32'(i));
      tick();
      check("alt_idle", {31'd0, busy}, 32'd0);
      check("alt_idle_av", {31'd0, mem_av}, 32'd0);
    end
    r0_av = 1'b0; r1_av = 1'b0; mem_valid = 1'b0;

    // Write from r1, inputs changed during BUSY must not disturb latches
    r1_av = 1'b1; r1_we = 1'b1; r1_addr = 32'h40; r1_wdata = 32'hDEADBEEF;
    tick();
    check("wr_we", {31'd0, mem_we}, 32'd1);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_addr", mem_addr, 32'h40);
    r1_we = 1'b0; r1_wdata = 32'h0; r1_addr = 32'h999;
    tick();
    check("wr_hold_we", {31'd0, mem_we}, 32'd1);
    check("wr_hold_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_hold_addr", mem_addr, 32'h40);
    mem_valid = 1'b1; mem_data = 32'h55;
    tick();
    check("wr_r1_v", {31'd0, r1_v}, 32'd1);
    check("wr_r0_v", {31'd0, r0_v}, 32'd0);
    check("wr_err", {31'd0, rsp_err}, 32'd0);
    check("wr_data", rsp_data, 32'h55);
    mem_valid = 1'b0; r1_av = 1'b0;
    tick();
    check("wr_once", {31'd0, r1_v}, 32'd0);

    // Timeout (MAX_WAIT=4); r0 drops its request while granted
    r0_av = 1'b1; r0_addr = 32'h300;
    tick();
    check("to_av1", {31'd0, mem_av}, 32'd1);
    check("to_addr", mem_addr, 32'h300);
    r0_av = 1'b0;
    tick();
    check("to_av2", {31'd0, mem_av}, 32'd1);
    tick();
    check("to_av3", {31'd0, mem_av}, 32'd1);
    tick();
    check("to_av4", {31'd0, mem_av}, 32'd1);
    check("to_no_strobe", {31'd0, r0_v}, 32'd0);
    tick();
    check("to_av_off", {31'd0, mem_av}, 32'd0);
    check("to_r0_v", {31'd0, r0_v}, 32'd1);
    check("to_err", {31'd0, rsp_err}, 32'd1);
    check("to_data", rsp_data, 32'h0);
    tick();
    mem_valid = 1'b1; mem_data = 32'hBAD;
    tick();
    check("late_r0_v", {31'd0, r0_v}, 32'd0);
    check("late_r1_v", {31'd0, r1_v}, 32'd0);
    check("late_busy", {31'd0, busy}, 32'd0);
    check("late_data", rsp_data, 32'h0);
    check("late_err", {31'd0, rsp_err}, 32'd1);
    mem_valid = 1'b0;

    // Reset mid-BUSY: r1 wins this tie (r0 was last), then reset discards it
    r0_av = 1'b1; r0_addr = 32'h100; r1_av = 1'b1; r1_addr = 32'h200;
    tick();
    check("rb_addr", mem_addr, 32'h200);
    check("rb_av", {31'd0, mem_av}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rb_av_drop", {31'd0, mem_av}, 32'd0);
    check("rb_busy_drop", {31'd0, busy}, 32'd0);
    tick();
    check("rb_no_r1_v", {31'd0, r1_v}, 32'd0);
    reset = 1'b1;
    tick();
    check("rb_regrant_addr", mem_addr, 32'h100);
    check("rb_regrant_r1_v", {31'd0, r1_v}, 32'd0);
    mem_valid = 1'b1; mem_data = 32'h77;
    tick();
    check("rb_r0_v", {31'd0, r0_v}, 32'd1);
    check("rb_r1_v", {31'd0, r1_v}, 32'd0);
    r0_av = 1'b0; r1_av = 1'b0; mem_valid = 1'b0;
    tick();

    // Single-cycle memory latency
    r1_av = 1'b1; r1_addr = 32'h80; r1_we = 1'b0;
    mem_valid = 1'b1; mem_data = 32'hCAFEF00D;
    tick();
    check("lat_busy1", {31'd0, busy}, 32'd1);
    check("lat_r1_v_early", {31'd0, r1_v}, 32'd0);
    tick();
    check("lat_busy2", {31'd0, busy}, 32'd1);
    check("lat_r1_v", {31'd0, r1_v}, 32'd1);
    check("lat_data", rsp_data, 32'hCAFEF00D);
    r1_av = 1'b0; mem_valid = 1'b0;
    tick();
    check("lat_busy_end", {31'd0, busy}, 32'd0);
    check("lat_r1_v_end", {31'd0, r1_v}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
